spi_frame_deserializer: RTL and testbench
=========================================

// Module: spi_frame_deserializer
// PURPOSE
//  Parametrised serial-to-parallel frame receiver for the SPI datapath.
//  Samples s_data on enable strobes into a bit-indexed shift register. Supports a
//  runtime frame length, MSB-first and LSB-first order, and framing. Presents completed
//  frames through a valid/ready holding register with overrun detection.
// PARAMETERS
//  BUS_WIDTH    8                      max frame width in bits (>=2)
//  CNT_WIDTH    $clog2(BUS_WIDTH+1)    width of bit counter / frame_len
// PORTS
//  clk          in   1          single clock; all logic on posedge
//  rst          in   1          asynchronous, active-high reset
//  enable       in   1          bit strobe: s_data sampled on this clk edge
//  s_data       in   1          serial input bit
//  frame_start  in   1          sync frame restart (SS assert); loads config
//  lsb_first    in   1          bit order for next frame (1 = LSB first)
//  frame_len    in   CNT_WIDTH  bits per frame; 0 or >BUS_WIDTH => BUS_WIDTH
//  p_data       out  BUS_WIDTH  completed frame, right-justified, upper bits 0
//  p_valid      out  1          p_data holds an unconsumed frame
//  p_ready      in   1          consumer accepts p_data when p_valid&&p_ready
//  overrun      out  1          sticky: frame completed while holding reg full
//  clr_ovr      in   1          synchronous clear of overrun
//  busy         out  1          partial frame in progress (bit_cnt != 0)
//  bit_cnt      out  CNT_WIDTH  bits received in current frame
// BEHAVIOUR
//  - Reset (async, rst=1): p_data=0, p_valid=0, overrun=0, bit_cnt=0, busy=0, sr=0.
//    Config regs: len=BUS_WIDTH, order=MSB-first.
//  - Config (len_q, lsb_q) loads from frame_len/lsb_first on frame_start.
//    It also loads on every frame completion, so back-to-back frames need no strobe.
//    Length clamp: 0 or >BUS_WIDTH -> BUS_WIDTH.
//  - Bit write on enable:
//    - LSB-first: sr[bit_cnt] <= s_data.
//    - MSB-first: sr[len_q-1-bit_cnt] <= s_data.
//    - Bits >= len_q remain 0.
//  - frame_start: bit_cnt<=0 and sr<=0; config reloads.
//    - With enable in the same cycle, the sampled bit becomes bit 0 of the new frame,
//      using the NEW config. bit_cnt then goes to 1.
//  - Completion: enable && effective bit_cnt==len_q-1.
//    - The assembled word, including the current bit, transfers to p_data on that edge.
//    - bit_cnt<=0 and sr<=0. p_valid is high from the next cycle.
//    - Latency: last bit edge -> p_valid high = 1 clk.
//  - Handshake:
//    - p_valid stays high and p_data stays stable until the cycle with p_valid&&p_ready.
//      p_valid then drops on the next edge.
//    - Completion in the same cycle as an accept: the new word loads and p_valid stays 1
//      with no bubble.
//    - Completion while p_valid&&!p_ready: the new word is dropped, p_data is kept, and
//      overrun is set.
//  - overrun is sticky until clr_ovr.
//    - If set and clear coincide, set wins.
//  - p_ready is ignored while p_valid=0.
//  - enable=0: no state change except handshake, clr_ovr and frame_start.
//  - rst mid-frame: the partial frame is discarded and the pending p_data is lost;
//    all state returns to reset values.
//  - frame_start mid-frame discards the partial bits and does not set overrun.
// TESTING
//  1. BUS_WIDTH=8, len=8, MSB-first, serial 1,0,1,1,0,0,1,0, p_ready=1
//     -> p_data=8'hB2, p_valid for 1 clk, 1 clk after the last bit.
//  2. len=8, LSB-first, same bit stream -> p_data=8'h4D.
//  3. len=5, MSB-first, bits 1,0,0,1,1 -> p_data=8'h13; busy=0 after completion.
//  4. p_ready=0, two 8-bit frames 8'hA5 then 8'h3C -> p_data stays 8'hA5 and overrun=1.
//     Then clr_ovr -> overrun=0. Then p_ready -> p_valid=0.
//  5. Three bits of a frame, then frame_start+enable with s_data=1, lsb_first=1,
//     then 7 more bits of 0 -> p_data=8'h01 and overrun=0.
//  6. Assert rst after 4 bits with p_valid=1 -> all outputs 0 immediately (async);
//     after release, a full frame 8'hFF is received correctly.

Source files
------------

// File: rtl/spi_frame_deserializer.sv
// Serial-to-parallel SPI frame receiver with runtime length, bit order,
// framing and a valid/ready holding register with sticky overrun.
module spi_frame_deserializer #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = $clog2(BUS_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 s_data,
    input  logic                 frame_start,
    input  logic                 lsb_first,
    input  logic [CNT_WIDTH-1:0] frame_len,
    output logic [BUS_WIDTH-1:0] p_data,
    output logic                 p_valid,
    input  logic                 p_ready,
    output logic                 overrun,
    input  logic                 clr_ovr,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] bit_cnt
);

    localparam logic [CNT_WIDTH-1:0] FULL_LEN = CNT_WIDTH'(BUS_WIDTH);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    // Out-of-range lengths fall back to the full bus width.
    function automatic logic [CNT_WIDTH-1:0] clamp_len(
        input logic [CNT_WIDTH-1:0] l
    );
        if (l == '0 || int'(l) > BUS_WIDTH) begin
            return FULL_LEN;
        end
        return l;
    endfunction

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic                 lsb_q, lsb_d;
    logic [BUS_WIDTH-1:0] sr_q, sr_d;
    logic [BUS_WIDTH-1:0] pdata_q, pdata_d;
    logic                 pvalid_q, pvalid_d;
    logic                 ovr_q, ovr_d;

    logic [CNT_WIDTH-1:0] cfg_len;
    logic [CNT_WIDTH-1:0] cur_len;
    logic                 cur_lsb;
    logic [CNT_WIDTH-1:0] eff_cnt;
    logic [BUS_WIDTH-1:0] sr_base;
    logic [CNT_WIDTH-1:0] idx;
    logic [BUS_WIDTH-1:0] word;
    logic                 last;

    // A frame_start restarts the frame with the new config before this
    // cycle's bit is placed, so the strobed bit lands as bit 0.
    always_comb begin
        cfg_len  = clamp_len(frame_len);
        cur_len  = frame_start ? cfg_len : len_q;
        cur_lsb  = frame_start ? lsb_first : lsb_q;
        eff_cnt  = frame_start ? '0 : cnt_q;
        sr_base  = frame_start ? '0 : sr_q;
        idx      = cur_lsb ? eff_cnt : (cur_len - ONE - eff_cnt);
        word     = sr_base;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            if (CNT_WIDTH'(i) == idx) begin
                word[i] = s_data;
            end
        end
        last     = enable && (eff_cnt == cur_len - ONE);

        cnt_d    = eff_cnt;
        sr_d     = sr_base;
        len_d    = cur_len;
        lsb_d    = cur_lsb;
        pdata_d  = pdata_q;
        pvalid_d = pvalid_q;
        ovr_d    = clr_ovr ? 1'b0 : ovr_q;

        if (last) begin
            cnt_d = '0;
            sr_d  = '0;
            len_d = cfg_len;
            lsb_d = lsb_first;
            if (!pvalid_q || p_ready) begin
                pdata_d  = word;
                pvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else begin
            if (enable) begin
                cnt_d = eff_cnt + ONE;
                sr_d  = word;
            end
            if (pvalid_q && p_ready) begin
                pvalid_d = 1'b0;
            end
        end
    end

    // State registers; reset discards any partial or pending frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            len_q    <= FULL_LEN;
            lsb_q    <= 1'b0;
            sr_q     <= '0;
            pdata_q  <= '0;
            pvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            lsb_q    <= lsb_d;
            sr_q     <= sr_d;
            pdata_q  <= pdata_d;
            pvalid_q <= pvalid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign p_data  = pdata_q;
    assign p_valid = pvalid_q;
    assign overrun = ovr_q;
    assign busy    = (cnt_q != '0);
    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_spi_frame_deserializer.sv
// Directed bench for spi_frame_deserializer with a queue-based
// frame model compared every cycle plus literal spot checks.
module tb_spi_frame_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       s_data = 1'b0;
    logic       frame_start = 1'b0;
    logic       lsb_first = 1'b0;
    logic [3:0] frame_len = 4'd8;
    logic [7:0] p_data;
    logic       p_valid;
    logic       p_ready = 1'b0;
    logic       overrun;
    logic       clr_ovr = 1'b0;
    logic       busy;
    logic [3:0] bit_cnt;

    int checks = 0;
    int errors = 0;

    spi_frame_deserializer #(.BUS_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .s_data(s_data),
        .frame_start(frame_start), .lsb_first(lsb_first),
        .frame_len(frame_len), .p_data(p_data), .p_valid(p_valid),
        .p_ready(p_ready), .overrun(overrun), .clr_ovr(clr_ovr),
        .busy(busy), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    // Model state: bits of the current frame in arrival order
    bit         mbits[$];
    int         mlen = 8;
    bit         mlsb = 1'b0;
    logic [7:0] mdata = 8'h00;
    bit         mvalid = 1'b0;
    bit         movr = 1'b0;

    function automatic int clampf(input logic [3:0] l);
        return (l == 0 || l > 8) ? 8 : int'(l);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0] w;
        bit done;
        bit acc;
        acc  = mvalid && p_ready;
        done = 1'b0;
        w    = 8'h00;
        if (frame_start) begin
            mbits.delete();
            mlen = clampf(frame_len);
            mlsb = lsb_first;
        end
        if (enable) begin
            mbits.push_back(s_data);
            if (mbits.size() == mlen) begin
                for (int k = 0; k < mlen; k++) begin
                    if (mlsb) w = w | (8'(mbits[k]) << k);
                    else      w = (w << 1) | 8'(mbits[k]);
                end
                done = 1'b1;
                mbits.delete();
                mlen = clampf(frame_len);
                mlsb = lsb_first;
            end
        end
        if (clr_ovr) movr = 1'b0;
        if (done) begin
            if (!mvalid || p_ready) begin
                mdata  = w;
                mvalid = 1'b1;
            end else begin
                movr = 1'b1;
            end
        end else if (acc) begin
            mvalid = 1'b0;
        end
    endtask

    // Reference model advances on the same edges as the DUT
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mbits.delete();
            mlen   = 8;
            mlsb   = 1'b0;
            mdata  = 8'h00;
            mvalid = 1'b0;
            movr   = 1'b0;
        end else begin
            model_step();
        end
    end

    // Compare DUT outputs against the model away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_p_data", 32'(p_data), 32'(mdata));
            chk("m_p_valid", 32'(p_valid), 32'(mvalid));
            chk("m_overrun", 32'(overrun), 32'(movr));
            chk("m_busy", 32'(busy), 32'(mbits.size() != 0));
            chk("m_bit_cnt", 32'(bit_cnt), 32'(mbits.size()));
        end
    end

    // Sends pat[n-1] first; ends at the negedge after the last bit edge
    task automatic send(input logic [7:0] pat, input int n,
                        input bit fs, input bit rdy_last);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            enable      = 1'b1;
            s_data      = pat[n-1-k];
            frame_start = fs && (k == 0);
            if (rdy_last && k == n - 1) p_ready = 1'b1;
        end
        @(negedge clk);
        enable      = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_p_data", 32'(p_data), 32'h0);
        chk("rst_p_valid", 32'(p_valid), 32'h0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'h0);
        rst = 1'b0;

        // MSB-first full frame
        frame_len = 4'd8; lsb_first = 1'b0; p_ready = 1'b1;
        send(8'b10110010, 8, 1'b1, 1'b0);
        chk("t1_valid", 32'(p_valid), 32'h1);
        chk("t1_data", 32'(p_data), 32'hB2);
        @(negedge clk);
        chk("t1_valid_drop", 32'(p_valid), 32'h0);

        // LSB-first, same stream
        lsb_first = 1'b1;
        send(8'b10110010, 8, 1'b1, 1'b0);
        chk("t2_data", 32'(p_data), 32'h4D);

        // Short frame
        frame_len = 4'd5; lsb_first = 1'b0;
        send(8'b00010011, 5, 1'b1, 1'b0);
        chk("t3_data", 32'(p_data), 32'h13);
        chk("t3_busy", 32'(busy), 32'h0);
        @(negedge clk);

        // Overrun while holding register full
        p_ready = 1'b0; frame_len = 4'd8;
        send(8'hA5, 8, 1'b1, 1'b0);
        send(8'h3C, 8, 1'b0, 1'b0);
        chk("t4_data", 32'(p_data), 32'hA5);
        chk("t4_ovr", 32'(overrun), 32'h1);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("t4_clr", 32'(overrun), 32'h0);
        p_ready = 1'b1;
        @(negedge clk);
        chk("t4_valid", 32'(p_valid), 32'h0);

        // Completion coinciding with accept: no bubble, no overrun
        p_ready = 1'b0;
        send(8'h11, 8, 1'b1, 1'b0);
        send(8'h22, 8, 1'b0, 1'b1);
        chk("t7_data", 32'(p_data), 32'h22);
        chk("t7_valid", 32'(p_valid), 32'h1);
        chk("t7_ovr", 32'(overrun), 32'h0);
        @(negedge clk);

        // Mid-frame restart with new config
        p_ready = 1'b1; lsb_first = 1'b0;
        send(8'b00000111, 3, 1'b1, 1'b0);
        lsb_first = 1'b1;
        send(8'h80, 8, 1'b1, 1'b0);
        chk("t5_data", 32'(p_data), 32'h01);
        chk("t5_ovr", 32'(overrun), 32'h0);

        // Length clamps: 0 and >8 both mean 8
        frame_len = 4'd0; lsb_first = 1'b0;
        send(8'hC3, 8, 1'b1, 1'b0);
        chk("clamp0", 32'(p_data), 32'hC3);
        frame_len = 4'd15; lsb_first = 1'b1;
        send(8'hE1, 8, 1'b1, 1'b0);
        chk("clamp15", 32'(p_data), 32'h87);

        // Async reset mid-frame with a pending word
        p_ready = 1'b0; frame_len = 4'd8; lsb_first = 1'b0;
        send(8'h5A, 8, 1'b1, 1'b0);
        send(8'h0F, 4, 1'b0, 1'b0);
        chk("t6_pre_cnt", 32'(bit_cnt), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("t6_p_data", 32'(p_data), 32'h0);
        chk("t6_p_valid", 32'(p_valid), 32'h0);
        chk("t6_overrun", 32'(overrun), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_bit_cnt", 32'(bit_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0; p_ready = 1'b1;
        send(8'hFF, 8, 1'b1, 1'b0);
        chk("t6_data", 32'(p_data), 32'hFF);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
